debug_reg_dumper: RTL and testbench
===================================

// Module: debug_reg_dumper
// PURPOSE
//  Sits beside the single-cycle RISC-V datapath on its debug port.
//  Drives Debug_Source and consumes Debug_Out/Debug_PC.
//  On a start pulse it snapshots PC, walks x0..x(NUM_REGS-1) and streams every word as bytes over a
//  valid/ready byte interface, for a UART TX or a trace FIFO.
//  Coherent dumps require the core to be halted or clock-gated by the system; this block does not stall the core.
// PARAMETERS
//  WIDTH     32  datapath word width; multiple of 8; BPW = WIDTH/8 bytes per word
//  NUM_REGS  32  registers dumped, indices 0..NUM_REGS-1 (<=32)
// PORTS
//  clk           in   1      system clock, rising edge
//  reset         in   1      asynchronous, active-high reset
//  start         in   1      request dump; sampled only in IDLE
//  Debug_PC      in   WIDTH  current PC from datapath
//  Debug_Out     in   WIDTH  register value selected by Debug_Source (combinational)
//  Debug_Source  out  5      register index presented to datapath
//  tx_data       out  8      byte to send
//  tx_valid      out  1      tx_data valid
//  tx_ready      in   1      consumer accepts byte when tx_valid&&tx_ready at clk edge
//  busy          out  1      high in any state other than IDLE
//  done          out  1      one-cycle pulse after final byte accepted
// BEHAVIOUR
//  Reset values: Debug_Source=0, tx_data=0, tx_valid=0, busy=0, done=0, state=IDLE, all counters 0.
//  State machine: IDLE, SEND, LOAD, CSUM (macro-dependent), FINISH.
//   IDLE: on start=1, shift<=Debug_PC, item<=0, byte<=0; next state SEND.
//    First tx_valid appears the cycle after start.
//   SEND: tx_valid=1, tx_data=shift[WIDTH-1 -: 8] (MSB first, big-endian).
//    On accept: shift<<=8, byte++.
//    If byte==BPW-1 on accept:
//     - item==NUM_REGS (last register): go to CSUM if enabled, else FINISH.
//     - otherwise: item++, Debug_Source<=item (the new item-1 index), go to LOAD.
//   LOAD: tx_valid=0 for exactly one cycle; shift<=Debug_Out; byte<=0; go to SEND.
//   FINISH: done=1 for one cycle, tx_valid=0; next state IDLE.
//  Item numbering: item 0 = PC, items 1..NUM_REGS = x0..x(NUM_REGS-1).
//  Stream length: (NUM_REGS+1)*BPW bytes, which is 132 at the defaults.
//  Handshake rules:
//   - tx_data and tx_valid hold stable while tx_valid && !tx_ready.
//   - tx_valid never drops without an accept.
//   - Minimum throughput: 1 byte/cycle inside a word, plus one bubble cycle per LOAD.
//  start while busy is ignored and not queued.
//  start held high across FINISH begins a new dump from IDLE on the following cycle.
//  x0 is dumped as read; the block does not force it to zero.
//  Reset asserted mid-dump aborts immediately with all outputs at reset values.
//   No partial word or done pulse is emitted after reset is released.
//  Counters saturate by construction; item never exceeds NUM_REGS, byte never exceeds BPW-1.
// CONFIGURATION
//  DEBUG_DUMP_CHECKSUM_EN defined:
//   - An 8-bit running XOR of every accepted byte is maintained; it is cleared on start.
//   - After the last register byte, state CSUM presents tx_data = XOR with tx_valid=1.
//   - CSUM follows the same hold rules; on accept, go to FINISH.
//   - Stream length is (NUM_REGS+1)*BPW+1 bytes.
//  DEBUG_DUMP_CHECKSUM_EN undefined: no XOR register, no CSUM state; last register byte goes to FINISH.
// TESTING
//  1. PC=0x00000040, x5=0x12345678, others 0, tx_ready=1, start pulse:
//     -> bytes 00 00 00 40, then x0..x4 all 00, x5 as 12 34 56 78;
//        132 bytes total; done pulses one cycle after the final accept; busy low afterwards.
//  2. Backpressure: tx_ready=0 for 5 cycles while the 2nd PC byte is presented
//     -> tx_data=00 and tx_valid=1 hold unchanged; stream resumes with no lost or duplicated byte.
//  3. Debug_Source check: during each LOAD cycle Debug_Source equals 0,1,...,31 in order;
//     captured word equals the model register file value at that cycle.
//  4. start pulsed at byte 50 while busy -> ignored; exactly one 132-byte stream and one done pulse.
//  5. reset asserted at byte 70 -> outputs at reset values immediately;
//     after release, no tx_valid until a new start; the new dump restarts at PC byte 0.
//  6. DEBUG_DUMP_CHECKSUM_EN defined, x1=0xFF000000, PC=0, others 0
//     -> 133 bytes; final byte 0xFF (XOR of all bytes).

Source files
------------

// File: rtl/debug_reg_dumper_if.sv
// Byte-stream valid/ready link from the register dumper to its consumer.
// Master drives tx_data/tx_valid; slave returns tx_ready.
interface debug_reg_dumper_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/debug_reg_dumper.sv
// Debug register dumper: snapshots PC, walks x0..x(NUM_REGS-1), streams bytes MSB first.
// Define DEBUG_DUMP_CHECKSUM_EN to append an XOR checksum byte to every dump.
module debug_reg_dumper #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Debug_PC,
  input  logic [WIDTH-1:0] Debug_Out,
  output logic [4:0]       Debug_Source,
  debug_reg_dumper_if.master tx,
  output logic             busy,
  output logic             done
);

  localparam int BPW = WIDTH / 8;
  localparam int IW  = $clog2(NUM_REGS + 1);
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    SEND,
    LOAD,
    CSUM,
    FINISH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    SEND,
    LOAD,
    FINISH
  } state_t;
`endif

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] shift;
  logic [IW-1:0]    item;
  logic [BW-1:0]    byte_cnt;
  logic             last_byte;
  logic             last_item;
  logic [7:0]       cur_byte;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign last_byte = (byte_cnt == BW'(BPW - 1));
  assign last_item = (item == IW'(NUM_REGS));
  assign cur_byte  = shift[WIDTH-1 -: 8];

  // State register; reset aborts any dump in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and Moore outputs; tx_data is only non-zero while offered.
  always_comb begin
    state_nx    = state;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = SEND;
        end
      end
      SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = cur_byte;
        if (tx.tx_ready && last_byte) begin
          if (last_item) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
            state_nx = CSUM;
`else
            state_nx = FINISH;
`endif
          end else begin
            state_nx = LOAD;
          end
        end
      end
      LOAD: begin
        state_nx = SEND;
      end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      CSUM: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = csum;
        if (tx.tx_ready) begin
          state_nx = FINISH;
        end
      end
`endif
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Word shifter, item/byte counters and register index presented to the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift        <= '0;
      item         <= '0;
      byte_cnt     <= '0;
      Debug_Source <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            shift    <= Debug_PC;
            item     <= '0;
            byte_cnt <= '0;
          end
        end
        SEND: begin
          if (tx.tx_ready) begin
            shift <= shift << 8;
            if (last_byte) begin
              byte_cnt <= '0;
              if (!last_item) begin
                item         <= item + IW'(1);
                Debug_Source <= 5'(item);
              end
            end else begin
              byte_cnt <= byte_cnt + BW'(1);
            end
          end
        end
        LOAD: begin
          shift    <= Debug_Out;
          byte_cnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DEBUG_DUMP_CHECKSUM_EN
  // Running XOR over every accepted register byte, cleared when a dump begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= 8'h00;
    end else if (state == IDLE && start) begin
      csum <= 8'h00;
    end else if (state == SEND && tx.tx_ready) begin
      csum <= csum ^ cur_byte;
    end
  end
`endif

  a_hold: assert property (
    @(posedge clk) disable iff (reset)
    (tx.tx_valid && !tx.tx_ready) |=> (tx.tx_valid && $stable(tx.tx_data))
  );

  a_item_range: assert property (
    @(posedge clk) disable iff (reset)
    item <= IW'(NUM_REGS)
  );

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Randomized self-checking bench for debug_reg_dumper.
// Expected streams come from a word-level model of PC plus register file.
module tb_debug_reg_dumper;

  localparam int W  = 32;
  localparam int NR = 32;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int SLEN = (NR + 1) * (W / 8) + 1;
`else
  localparam int SLEN = (NR + 1) * (W / 8);
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] pc;
  logic [W-1:0] dbg_out;
  logic [4:0]   dbg_src;
  logic         busy;
  logic         done;
  logic [W-1:0] regs [NR];

  debug_reg_dumper_if tx_if ();

  debug_reg_dumper #(
    .WIDTH    (W),
    .NUM_REGS (NR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .Debug_PC     (pc),
    .Debug_Out    (dbg_out),
    .Debug_Source (dbg_src),
    .tx           (tx_if),
    .busy         (busy),
    .done         (done)
  );

  assign dbg_out = regs[dbg_src];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] got [$];
  logic [7:0] exp [$];
  logic [4:0] ld_src [$];
  int cyc = 0;
  int last_acc = 0;
  int done_cyc = 0;
  int done_cnt = 0;

  // Observe the link at negedge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        got.push_back(tx_if.tx_data);
        last_acc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy && !tx_if.tx_valid && !done) begin
        ld_src.push_back(dbg_src);
      end
    end
  end

  task automatic build_expected();
    logic [W-1:0] w;
    logic [7:0] x;
    exp.delete();
    x = 8'h00;
    for (int it = 0; it <= NR; it++) begin
      w = (it == 0) ? pc : regs[it-1];
      for (int b = 0; b < W / 8; b++) begin
        exp.push_back(8'((w >> (W - 8 - 8 * b)) & 'hFF));
        x = x ^ exp[$];
      end
    end
`ifdef DEBUG_DUMP_CHECKSUM_EN
    exp.push_back(x);
`endif
  endtask

  task automatic clear_mon();
    got.delete();
    ld_src.delete();
    done_cnt = 0;
    last_acc = 0;
    done_cyc = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rnd) tx_if.tx_ready = ($urandom_range(0, 3) != 0);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    tx_if.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    tx_if.tx_ready = 1'b1;
    pc = '0;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (tx_if.tx_valid !== 1'b0 || tx_if.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx: valid=%b data=%h want 0/00", tx_if.tx_valid, tx_if.tx_data);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_src !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b done=%b src=%0d want 0", busy, done, dbg_src);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    bit ok;
    pc = 32'h0000_0040;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    regs[5] = 32'h1234_5678;
    build_expected();
    clear_mon();
    pulse_start();
    @(negedge clk);
    vectors++;
    if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL first_valid: valid=%b data=%h want 1/00", tx_if.tx_valid, tx_if.tx_data);
    end
    wait_done(2000, 1'b0, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL dir_timeout: done=0 want 1");
    end
    vectors++;
    if (got.size() != SLEN) begin
      errors++;
      $display("FAIL dir_len: got %0d want %0d", got.size(), SLEN);
    end
    for (int i = 0; i < SLEN && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL dir_byte[%0d]: got %h want %h", i, got[i], exp[i]);
      end
    end
    vectors++;
    if (done_cnt != 1 || done_cyc - last_acc != 1) begin
      errors++;
      $display("FAIL dir_done: cnt=%0d lag=%0d want 1/1", done_cnt, done_cyc - last_acc);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL dir_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    pc = $urandom & 32'hFF00_FFFF;
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    build_expected();
    clear_mon();
    tx_if.tx_ready = 1'b1;
    pulse_start();
    @(posedge clk); #1;
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== exp[1]) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h want 1/%h", i, tx_if.tx_valid,
                 tx_if.tx_data, exp[1]);
      end
      @(posedge clk); #1;
    end
    tx_if.tx_ready = 1'b1;
    wait_done(2000, 1'b0, ok);
    vectors++;
    if (!ok || got.size() != SLEN) begin
      errors++;
      $display("FAIL bp_len: ok=%b got %0d want %0d", ok, got.size(), SLEN);
    end
    for (int i = 0; i < SLEN && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL bp_byte[%0d]: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_debug_source();
    bit ok;
    pc = $urandom;
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    build_expected();
    clear_mon();
    pulse_start();
    wait_done(4000, 1'b1, ok);
    vectors++;
    if (!ok || ld_src.size() != NR) begin
      errors++;
      $display("FAIL src_count: ok=%b loads %0d want %0d", ok, ld_src.size(), NR);
    end
    for (int i = 0; i < NR && i < ld_src.size(); i++) begin
      vectors++;
      if (ld_src[i] !== 5'(i)) begin
        errors++;
        $display("FAIL src_idx[%0d]: got %0d want %0d", i, ld_src[i], i);
      end
    end
    vectors++;
    if (got.size() != SLEN) begin
      errors++;
      $display("FAIL src_len: got %0d want %0d", got.size(), SLEN);
    end
    for (int i = 0; i < SLEN && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL src_byte[%0d]: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    bit pulsed;
    pc = $urandom;
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    build_expected();
    clear_mon();
    pulse_start();
    pulsed = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (got.size() == 50 && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (done_cnt > 0) ok = 1'b1;
    end
    start = 1'b0;
    repeat (SLEN + 20) @(posedge clk);
    #1;
    vectors++;
    if (!ok || !pulsed || got.size() != SLEN || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_start: ok=%b len=%0d dones=%0d want 1/%0d/1", ok, got.size(),
               done_cnt, SLEN);
    end
    for (int i = 0; i < SLEN && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL busy_byte[%0d]: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    int stray;
    pc = $urandom;
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    build_expected();
    clear_mon();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(posedge clk); #1;
      if (got.size() >= 70) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_reach: bytes %0d want 70", got.size());
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({tx_if.tx_valid, tx_if.tx_data, busy, done, dbg_src} !== '0) begin
      errors++;
      $display("FAIL rst_mid: valid=%b data=%h busy=%b done=%b src=%0d want 0",
               tx_if.tx_valid, tx_if.tx_data, busy, done, dbg_src);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_if.tx_valid || done || busy) stray++;
    end
    vectors++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_quiet: active cycles %0d want 0", stray);
    end
    pulse_start();
    wait_done(2000, 1'b0, ok);
    vectors++;
    if (!ok || got.size() != SLEN) begin
      errors++;
      $display("FAIL rst_redump: ok=%b len %0d want %0d", ok, got.size(), SLEN);
    end
    for (int i = 0; i < SLEN && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL rst_byte[%0d]: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

`ifdef DEBUG_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    pc = '0;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    regs[1] = 32'hFF00_0000;
    clear_mon();
    pulse_start();
    wait_done(2000, 1'b1, ok);
    vectors++;
    if (!ok || got.size() != 133) begin
      errors++;
      $display("FAIL csum_len: ok=%b len %0d want 133", ok, got.size());
    end
    vectors++;
    if (got.size() == 0 || got[$] !== 8'hFF) begin
      errors++;
      $display("FAIL csum_byte: got %h want ff", (got.size() != 0) ? got[$] : 8'h00);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_debug_source();
    test_start_while_busy();
    test_reset_mid();
`ifdef DEBUG_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
